// File: rtl/memory_test_hw_led_seq_pkg.sv
// LED sequencer shared definitions.
// CSR offsets, register bit positions and FSM state type.
package memory_test_hw_led_seq_pkg;

  localparam logic [3:0] CSR_CTRL   = 4'd0;
  localparam logic [3:0] CSR_STATUS = 4'd1;
  localparam logic [3:0] CSR_PERIOD = 4'd2;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_LAST   = 4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_IDX  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/memory_test_hw_led_seq_timer.sv
// LED sequencer step timer.
// Loadable down-counter; expired is high while the count is 1.
module memory_test_hw_led_seq_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] count;

  // load wins over decrement; count saturates at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/memory_test_hw_led_sequencer.sv
// LED sequencer: steps an 8-entry pattern table out to an LED PIO
// through a write-only master port, with a per-step hold period.
module memory_test_hw_led_sequencer
  import memory_test_hw_led_seq_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int DEPTH    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  csr_address,
  input  logic        csr_chipselect,
  input  logic        csr_write_n,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic        pio_waitrequest,
  output logic        irq
);

  state_t state, state_n;

  logic                ctrl_run;
  logic                ctrl_loop;
  logic                ctrl_irq_en;
  logic [2:0]          ctrl_last;
  logic                done;
  logic [2:0]          index, index_n;
  logic [PERIOD_W-1:0] period;
  logic [7:0]          pattern [DEPTH];
  logic [7:0]          led;

  logic csr_wr, ctrl_wr, stat_wr, per_wr, pat_wr;
  logic run_sw, start, go_write, finish;
  logic t_load, t_dec, t_exp;
  logic [PERIOD_W-1:0] t_val;

  logic unused_wdata;
  assign unused_wdata = ^csr_writedata[31:PERIOD_W];

  assign csr_wr  = csr_chipselect && !csr_write_n;
  assign ctrl_wr = csr_wr && csr_address == CSR_CTRL;
  assign stat_wr = csr_wr && csr_address == CSR_STATUS;
  assign per_wr  = csr_wr && csr_address == CSR_PERIOD;
  assign pat_wr  = csr_wr && csr_address[3];

  // run as software leaves it this cycle, before hardware completion
  assign run_sw = ctrl_wr ? csr_writedata[CTRL_RUN] : ctrl_run;
  assign start  = state == ST_IDLE && ctrl_wr &&
                  csr_writedata[CTRL_RUN] && !ctrl_run;
  assign t_val  = (period == '0) ? PERIOD_W'(1) : period;

  memory_test_hw_led_seq_timer #(.W(PERIOD_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .expired  (t_exp)
  );

  // state and step index registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      index <= '0;
    end else begin
      state <= state_n;
      index <= index_n;
    end
  end

  // next state, step advance and timer control
  always_comb begin
    state_n  = state;
    index_n  = index;
    t_load   = 1'b0;
    t_dec    = 1'b0;
    go_write = 1'b0;
    finish   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n  = ST_WRITE;
          index_n  = '0;
          go_write = 1'b1;
        end
      end
      ST_WRITE: begin
        if (!pio_waitrequest) begin
          t_load  = 1'b1;
          state_n = run_sw ? ST_WAIT : ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!run_sw) begin
          state_n = ST_IDLE;
        end else begin
          t_dec = 1'b1;
          if (t_exp) begin
            if (index < ctrl_last) begin
              index_n  = index + 3'd1;
              state_n  = ST_WRITE;
              go_write = 1'b1;
            end else if (ctrl_loop) begin
              index_n  = '0;
              state_n  = ST_WRITE;
              go_write = 1'b1;
            end else begin
              finish  = 1'b1;
              state_n = ST_IDLE;
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // CSR registers; hardware done-set beats software W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_run    <= 1'b0;
      ctrl_loop   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_last   <= '0;
      done        <= 1'b0;
      period      <= '0;
    end else begin
      ctrl_run <= finish ? 1'b0 : run_sw;
      if (ctrl_wr) begin
        ctrl_loop   <= csr_writedata[CTRL_LOOP];
        ctrl_irq_en <= csr_writedata[CTRL_IRQ_EN];
        ctrl_last   <= csr_writedata[CTRL_LAST+:3];
      end
      done <= finish ||
              (done && !(stat_wr && csr_writedata[STAT_DONE]));
      if (per_wr) period <= csr_writedata[PERIOD_W-1:0];
    end
  end

  // pattern table held in flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pattern[i] <= '0;
    end else if (pat_wr) begin
      pattern[csr_address[2:0]] <= csr_writedata[7:0];
    end
  end

  // LED value fetched on entry to WRITE, held until the next fetch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) led <= '0;
    else if (go_write) led <= pattern[index_n];
  end

  assign pio_address    = 2'b00;
  assign pio_chipselect = state == ST_WRITE;
  assign pio_write_n    = state != ST_WRITE;
  assign pio_writedata  = {24'b0, led};
  assign irq            = done && ctrl_irq_en;

  // CSR read mux
  always_comb begin
    csr_readdata = '0;
    unique case (1'b1)
      csr_address[3]: begin
        csr_readdata[7:0] = pattern[csr_address[2:0]];
      end
      csr_address == CSR_CTRL: begin
        csr_readdata[CTRL_RUN]      = ctrl_run;
        csr_readdata[CTRL_LOOP]     = ctrl_loop;
        csr_readdata[CTRL_IRQ_EN]   = ctrl_irq_en;
        csr_readdata[CTRL_LAST+:3]  = ctrl_last;
      end
      csr_address == CSR_STATUS: begin
        csr_readdata[STAT_BUSY]    = state != ST_IDLE;
        csr_readdata[STAT_DONE]    = done;
        csr_readdata[STAT_IDX+:3]  = index;
      end
      csr_address == CSR_PERIOD: begin
        csr_readdata[PERIOD_W-1:0] = period;
      end
      default: csr_readdata = '0;
    endcase
  end

endmodule
